// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the sequential shift unit.
package shift_pkg;

   localparam logic [2:0] OP_SHR  = 3'b000;
   localparam logic [2:0] OP_SHRA = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 32;
   localparam int CNT_W     = $clog2(DEF_WIDTH);

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

   // Codes 101..111 all mean PASS.
   function automatic logic is_pass(input logic [2:0] op);
      return op > OP_ROL;
   endfunction

endpackage

// File: rtl/shift_step.sv
// One shift step of 0..STEP positions; a STEP-way mux of constant shifts.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   parameter int KW    = 6
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [2:0]       op_i,
   input  logic [KW-1:0]    k_i,
   output logic [WIDTH-1:0] acc_o
);

   always_comb begin
      acc_o = acc_i;
      for (int i = 1; i <= STEP; i++) begin
         if (k_i == KW'(i)) begin
            case (op_i)
               OP_SHR:  acc_o = acc_i >> i;
               OP_SHRA: acc_o = $signed(acc_i) >>> i;
               OP_SHL:  acc_o = acc_i << i;
               OP_ROR:  acc_o = (acc_i >> i) | (acc_i << (WIDTH - i));
               OP_ROL:  acc_o = (acc_i << i) | (acc_i >> (WIDTH - i));
               default: acc_o = acc_i;
            endcase
         end
      end
   end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: shifts up to STEP positions per clock until the count is used up.
//   state | meaning
//   IDLE  | waiting for start; done pulse appears here after DONE
//   SHIFT | applying min(STEP,cnt) positions per edge
//   DONE  | publishing acc to result/zero on the next edge
module seq_shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic                     clock,
   input  logic                     clear,
   input  logic                     start,
   input  logic [2:0]               op,
   input  logic [WIDTH-1:0]         data_in,
   input  logic [$clog2(WIDTH)-1:0] amount,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH-1:0]         result,
   output logic                     zero
);

   localparam int AW = cnt_w(WIDTH);
   localparam int KW = AW + 1;

   state_e           state_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [AW-1:0]    cnt_q;
   logic [2:0]       op_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic [KW-1:0]    k;

   assign k = ({1'b0, cnt_q} >= KW'(STEP)) ? KW'(STEP) : {1'b0, cnt_q};

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .KW    (KW)
   ) u_step (
      .acc_i (acc_q),
      .op_i  (op_q),
      .k_i   (k),
      .acc_o (acc_d)
   );

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  acc_q  <= data_in;
                  op_q   <= op;
                  cnt_q  <= amount;
                  busy_q <= 1'b1;
                  if (amount == '0 || is_pass(op)) state_q <= ST_DONE;
                  else                             state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - k[AW-1:0];
               if (cnt_q == k[AW-1:0]) state_q <= ST_DONE;
            end
            ST_DONE: begin
               done_q   <= 1'b1;
               result_q <= acc_q;
               zero_q   <= (acc_q == '0);
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 Parameter: WIDTH, default 32, data word width in bits; legal range 8..64.
REQ-002 Parameter: STEP, default 1, maximum bit positions shifted per cycle; a power of two, 1..WIDTH.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: clear  input  1  reset; asynchronous, active-high.
REQ-005 Port: start  input  1  request to begin an operation; sampled on the rising edge.
REQ-006 Port: op  input  3  operation: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101-111 PASS.
REQ-007 Port: data_in  input  WIDTH  operand to be shifted.
REQ-008 Port: amount  input  clog2(WIDTH)  shift count; range 0..WIDTH-1.
REQ-009 Port: busy  output  1  high in SHIFT and DONE states.
REQ-010 Port: done  output  1  one-cycle pulse; result is valid while done is high.
REQ-011 Port: result  output  WIDTH  shifted word.
REQ-012 Port: zero  output  1  high when result equals 0; updated together with result.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch op and data_in into acc and amount into cnt.
- Next state SHALL be DONE if amount=0 or op is PASS.
- Otherwise next state SHALL be SHIFT.
REQ-015 Each edge in SHIFT SHALL update acc by k=min(STEP,cnt) positions and decrement cnt by k; when cnt reaches 0, next state SHALL be DONE.
REQ-016 Per-step rules:
- SHR: zero fill from MSB.
- SHRA: fill with acc MSB.
- SHL: zero fill from LSB.
- ROR/ROL: rotate through bits with no loss.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, result and zero SHALL take acc, and the next state SHALL be IDLE.
REQ-018 Latency from the accepting edge to done high SHALL be ceil(amount/STEP)+1 cycles; amount=0 or PASS SHALL take 1 cycle.
REQ-019 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-020 result and zero SHALL hold their last values until the next DONE.
REQ-021 Changes on op, data_in or amount after acceptance SHALL NOT affect the operation in flight.
REQ-022 For a given (op, data_in, amount), the final result SHALL be independent of STEP.

Reset
REQ-023 While clear=1, the block SHALL force: state=IDLE, acc=0, cnt=0, busy=0, done=0, result=0, zero=1.
REQ-024 clear asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-025 start SHALL be honoured on the first rising edge after clear deasserts.

Structure
REQ-026 Package shift_pkg SHALL hold:
- the op encodings;
- the FSM state typedef;
- helper constant CNT_W = clog2(WIDTH).
REQ-027 One combinational sub-module shift_step SHALL compute a single step: acc, op and k in, next acc out. It SHALL be instantiated once.
REQ-028 No multiplier and no full-width barrel shifter SHALL be used when STEP<WIDTH.

Verification
REQ-029 WIDTH=32, STEP=1: SHR of 0x00000019 by 3 -> result 0x00000003, done exactly 4 cycles after the start edge.
REQ-030 STEP=1: SHRA of 0x80000000 by 4 -> 0xF8000000. Same stimulus with STEP=4 -> same value, done 2 cycles after start.
REQ-031 ROR of 0x00000001 by 1 -> 0x80000000. ROL of 0x80000000 by 31 -> 0x40000000. SHL of 0x00000018 by 31 -> 0x00000000 with zero=1.
REQ-032 amount=0 with op SHR and data 0x12345678 -> result 0x12345678, done 1 cycle after start. op=111 -> same result and timing.
REQ-033 start pulsed again during SHIFT with different data -> ignored; the first operation's result and timing are unchanged.
REQ-034 clear during SHIFT -> busy=0, result=0 and zero=1 immediately, no done pulse. A new start after clear completes normally.
